// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// registers fetched words into IF/ID with a valid/ready handshake to decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_instr,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] br_pc,
    input  logic [25:0] br_imm,
    input  logic [31:0] jr_reg,
    output logic [31:0] pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        halted,
    output logic        err_misalign,
    output logic        err_oob
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0] RT_BR   = 2'b00;
    localparam logic [1:0] RT_J    = 2'b01;
    localparam logic [1:0] RT_JR   = 2'b10;
    localparam logic [1:0] RT_RSVD = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        err_mis_q, err_mis_d;
    logic        err_oob_q, err_oob_d;

    logic [29:0] pc_off;
    logic        in_window;
    logic        redir_en;
    logic        fire;
    logic [31:0] target;

    // RESET_PC is word aligned, so the low PC bits never borrow into the word offset.
    assign pc_off    = pc_q[31:2] - RESET_PC[31:2];
    assign im_addr   = pc_off[9:0];
    assign in_window = (pc_off[29:10] == 20'd0);

    assign redir_en = redirect && (redirect_type != RT_RSVD) && (state_q != IDLE);
    assign fire     = (state_q == RUN) && (!if_valid_q || id_ready) && !redir_en;

    always_comb begin
        target = {jr_reg[31:2], 2'b00};
        case (redirect_type)
            RT_BR:   target = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm[15:0], 2'b00};
            RT_J:    target = {br_pc[31:28], br_imm, 2'b00};
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        err_mis_d  = err_mis_q;
        err_oob_d  = err_oob_q;

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (fire && (im_instr == HALT_WORD)) state_d = HALT;
            HALT:    ;
            default: state_d = IDLE;
        endcase

        // A redirect flushes IF/ID and cancels any halt fetched on the wrong path.
        if (redir_en) begin
            state_d    = RUN;
            pc_d       = target;
            if_valid_d = 1'b0;
            if ((redirect_type == RT_JR) && (jr_reg[1:0] != 2'b00)) err_mis_d = 1'b1;
        end else if (fire) begin
            if_instr_d = im_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (im_instr != HALT_WORD) pc_d = pc_q + 32'd4;
            if (!in_window) err_oob_d = 1'b1;
        end else if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
            if_valid_q <= 1'b0;
            err_mis_q  <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            err_mis_q  <= err_mis_d;
            err_oob_q  <= err_oob_d;
        end
    end

    assign pc           = pc_q;
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign if_valid     = if_valid_q;
    assign halted       = (state_q == HALT);
    assign err_misalign = err_mis_q;
    assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed sequences, a redirect vector
// table and randomized traffic compared against a behavioural fetch model.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] HW  = 32'h0000_000C;

    logic        clk;
    logic        reset_n;
    logic [9:0]  im_addr;
    logic [31:0] im_instr;
    logic        rdy;
    logic        rdr;
    logic [1:0]  rtype;
    logic [31:0] bpc;
    logic [25:0] bimm;
    logic [31:0] jreg;
    logic [31:0] pc, if_instr, if_pc;
    logic        if_valid, halted, err_misalign, err_oob;

    logic [31:0] rom [0:1023];
    assign im_instr = rom[im_addr];

    ifu_fetch #(.RESET_PC(RPC), .HALT_WORD(HW)) dut (
        .clk(clk), .reset_n(reset_n), .im_addr(im_addr), .im_instr(im_instr),
        .id_ready(rdy), .redirect(rdr), .redirect_type(rtype), .br_pc(bpc),
        .br_imm(bimm), .jr_reg(jreg), .pc(pc), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .halted(halted), .err_misalign(err_misalign), .err_oob(err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = just out of reset, 1 = fetching, 2 = halted.
    logic [31:0] m_pc, m_instr, m_ifpc;
    logic        m_valid, m_mis, m_oob;
    int          m_mode;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - RPC;
        return (d >> 2) % 1024;
    endfunction

    task automatic model_step();
        logic [31:0] w, ea;
        bit eff, fire;
        if (m_mode == 0) begin
            m_mode = 1;
            return;
        end
        eff  = rdr && (rtype != 2'b11);
        fire = (m_mode == 1) && (!m_valid || rdy) && !eff;
        if (eff) begin
            case (rtype)
                2'd0: m_pc = bpc + 32'd4 + 32'(4 * int'($signed(bimm[15:0])));
                2'd1: m_pc = (bpc & 32'hF000_0000) | (32'(bimm) * 32'd4);
                default: begin
                    m_pc = jreg & ~32'd3;
                    if (jreg % 4 != 0) m_mis = 1'b1;
                end
            endcase
            m_valid = 1'b0;
            m_mode  = 1;
        end else if (fire) begin
            ea = word_of(m_pc);
            w  = rom[ea[9:0]];
            if ((m_pc - RPC) >= 32'd4096) m_oob = 1'b1;
            m_instr = w;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            if (w == HW) m_mode = 2;
            else m_pc = m_pc + 32'd4;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("im_addr", 32'(im_addr), word_of(m_pc));
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ifpc);
        end
        chk("halted", 32'(halted), (m_mode == 2) ? 32'd1 : 32'd0);
        chk("err_misalign", 32'(err_misalign), 32'(m_mis));
        chk("err_oob", 32'(err_oob), 32'(m_oob));
    endtask

    // Called at a falling edge: inputs in place, model advanced, one clock, compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Called at a falling edge: pulse reset low mid-cycle and check the async clear.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_pc = RPC; m_instr = 32'd0; m_ifpc = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0; m_oob = 1'b0; m_mode = 0;
        chk("rst_pc", pc, RPC);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err_misalign", 32'(err_misalign), 32'd0);
        chk("rst_err_oob", 32'(err_oob), 32'd0);
        #2;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [31:0] bp;
        logic [25:0] bi;
        logic [31:0] jr;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } rvec_t;

    rvec_t tbl [7];

    initial begin
        logic [31:0] lin;
        int off;

        reset_n = 1'b0;
        rdy = 1'b1; rdr = 1'b0; rtype = 2'd0; bpc = 32'd0; bimm = 26'd0; jreg = 32'd0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | 32'(i);
        for (int i = 0; i < 4; i++) rom[i] = 32'h1111_1111 * 32'(i + 1);

        tbl[0] = '{2'd0, 32'h0000_3008, 26'h000_FFFE, 32'h0, 32'h0000_3004, 1'b0};
        tbl[1] = '{2'd0, 32'h0000_3000, 26'h000_0003, 32'h0, 32'h0000_3010, 1'b0};
        tbl[2] = '{2'd0, 32'h0000_3100, 26'h000_8000, 32'h0, 32'hFFFE_3104, 1'b0};
        tbl[3] = '{2'd1, 32'h0000_3008, 26'h000_0C10, 32'h0, 32'h0000_3040, 1'b0};
        tbl[4] = '{2'd1, 32'hF000_0000, 26'h3FF_FFFF, 32'h0, 32'hFFFF_FFFC, 1'b0};
        tbl[5] = '{2'd2, 32'h0, 26'h0, 32'h0000_3013, 32'h0000_3010, 1'b1};
        tbl[6] = '{2'd2, 32'h0, 26'h0, 32'h0000_3020, 32'h0000_3020, 1'b0};

        @(negedge clk);

        // Linear fetch
        do_reset();
        tick();
        chk("idle_if_valid", 32'(if_valid), 32'd0);
        chk("idle_pc", pc, 32'h0000_3000);
        chk("idle_im_addr", 32'(im_addr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            lin = 32'h1111_1111 * 32'(k + 1);
            chk("lin_if_pc", if_pc, 32'h0000_3000 + 32'(4 * k));
            chk("lin_if_instr", if_instr, lin);
            chk("lin_im_addr", 32'(im_addr), 32'(k + 1));
        end

        // Stall with if_pc = 0x3004
        do_reset();
        tick(); tick(); tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_if_pc", if_pc, 32'h0000_3004);
            chk("stall_if_instr", if_instr, 32'h2222_2222);
            chk("stall_pc", pc, 32'h0000_3008);
            chk("stall_if_valid", 32'(if_valid), 32'd1);
        end
        rdy = 1'b1;
        tick();
        chk("unstall_if_pc", if_pc, 32'h0000_3008);
        chk("unstall_if_instr", if_instr, 32'h3333_3333);

        // Redirect vector table
        for (int v = 0; v < 7; v++) begin
            do_reset();
            rdy = 1'b1; rdr = 1'b0;
            tick(); tick();
            rdr = 1'b1; rtype = tbl[v].t; bpc = tbl[v].bp; bimm = tbl[v].bi; jreg = tbl[v].jr;
            tick();
            chk("redir_pc", pc, tbl[v].exp_pc);
            chk("redir_flush", 32'(if_valid), 32'd0);
            chk("redir_misalign", 32'(err_misalign), 32'(tbl[v].exp_mis));
            rdr = 1'b0;
            tick();
            chk("redir_if_pc", if_pc, tbl[v].exp_pc);
            chk("redir_if_valid", 32'(if_valid), 32'd1);
            chk("redir_oob", 32'(err_oob), ((tbl[v].exp_pc - RPC) >= 32'd4096) ? 32'd1 : 32'd0);
        end

        // Halt on syscall, then leave via j
        rom[2] = HW;
        do_reset();
        rdy = 1'b1; rdr = 1'b0;
        tick(); tick(); tick(); tick();
        chk("halt_if_pc", if_pc, 32'h0000_3008);
        chk("halt_if_instr", if_instr, HW);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'h0000_3008);
        rdy = 1'b0;
        tick();
        chk("halt_hold_valid", 32'(if_valid), 32'd1);
        rdy = 1'b1;
        tick();
        chk("halt_consumed", 32'(if_valid), 32'd0);
        tick();
        chk("halt_frozen_pc", pc, 32'h0000_3008);
        chk("halt_still", 32'(halted), 32'd1);
        chk("halt_no_fetch", 32'(if_valid), 32'd0);
        rdr = 1'b1; rtype = 2'd1; bpc = 32'h0000_3000; bimm = 26'h000_0C00;
        tick();
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_pc", pc, 32'h0000_3000);
        rdr = 1'b0;
        tick();
        chk("unhalt_if_pc", if_pc, 32'h0000_3000);
        chk("unhalt_if_instr", if_instr, 32'h1111_1111);
        rom[2] = 32'h3333_3333;

        // Async reset mid-stall with sticky error set, then out-of-window fetch
        do_reset();
        rdy = 1'b1;
        tick();
        rdr = 1'b1; rtype = 2'd2; jreg = 32'h0000_3013;
        tick();
        chk("jr_pc", pc, 32'h0000_3010);
        chk("jr_misalign", 32'(err_misalign), 32'd1);
        rdr = 1'b0;
        tick();
        rdy = 1'b0;
        tick();
        chk("prerst_valid", 32'(if_valid), 32'd1);
        chk("prerst_misalign", 32'(err_misalign), 32'd1);
        do_reset();
        rdy = 1'b1;
        tick();
        rdr = 1'b1; rtype = 2'd1; bpc = 32'h0000_0000; bimm = 26'h000_1000;
        tick();
        chk("oob_pc", pc, 32'h0000_4000);
        chk("oob_im_addr", 32'(im_addr), 32'd0);
        chk("oob_before", 32'(err_oob), 32'd0);
        rdr = 1'b0;
        tick();
        chk("oob_set", 32'(err_oob), 32'd1);
        chk("oob_if_pc", if_pc, 32'h0000_4000);
        chk("oob_if_instr", if_instr, 32'h1111_1111);

        // Randomized traffic against the model
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 1024; i++)
                rom[i] = ($urandom_range(0, 39) == 0) ? HW : $urandom;
            do_reset();
            for (int n = 0; n < 500; n++) begin
                if ($urandom_range(0, 199) == 0) do_reset();
                rdy   = ($urandom_range(0, 3) != 0);
                rdr   = ($urandom_range(0, 9) == 0);
                rtype = 2'($urandom_range(0, 3));
                bpc   = 32'h0000_3000 + ($urandom_range(0, 1023) << 2);
                jreg  = 32'h0000_3000 + ($urandom_range(0, 1023) << 2)
                      + (($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0);
                if (rtype == 2'd0) begin
                    off  = int'($urandom_range(0, 200)) - 100;
                    bimm = {10'($urandom), off[15:0]};
                end else begin
                    bimm = 26'(32'h0000_0C00 + $urandom_range(0, 1100));
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
